// File: rtl/input_neuron_array.sv
// input_neuron_array: per-channel input spike latch with saturating
// "steps since last spike" counters, a valid/ready step handshake,
// channel enables, an optional refractory period and a spike popcount.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   step_valid      time-step request from the spike encoder
//   step_ready      high while idle and no img_start is pending
//   spike_in        input spikes, captured when the step is accepted
//   chan_en         per-channel enable, captured when the step is accepted
//   img_start       synchronous reinitialisation of all channel state
//   spike_out       registered spikes of the last completed step
//   count           packed counters, channel i = count[i*CW +: CW]
//   spike_total     number of spike_out bits set
//   done            one-cycle pulse when the outputs hold a new step
module input_neuron_array #(
    parameter int N_CH       = 16,
    parameter int CW         = 8,
    parameter int T_MAX      = 21,
    parameter int REFRAC     = 0,
    parameter int PREV_SPIKE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      step_valid,
    output logic                      step_ready,
    input  logic [N_CH-1:0]           spike_in,
    input  logic [N_CH-1:0]           chan_en,
    input  logic                      img_start,
    output logic [N_CH-1:0]           spike_out,
    output logic [N_CH*CW-1:0]        count,
    output logic [$clog2(N_CH+1)-1:0] spike_total,
    output logic                      done
);

    localparam int TW = $clog2(N_CH + 1);
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CALC = 1'b1;

    localparam logic [CW-1:0] T_MAX_V  = CW'(T_MAX);
    localparam logic [RW-1:0] REFRAC_V = RW'(REFRAC);

    logic [0:0]         state_q, state_d;
    logic [N_CH-1:0]    spk_hold_q, spk_hold_d;
    logic [N_CH-1:0]    en_hold_q, en_hold_d;
    logic [N_CH-1:0]    spike_out_q, spike_out_d;
    logic [N_CH*CW-1:0] count_q, count_d;
    logic [TW-1:0]      total_q, total_d;
    logic               done_q, done_d;
    logic [RW-1:0]      refr_q [N_CH];
    logic [RW-1:0]      refr_d [N_CH];

    // Result of the step currently held in the CALC state.
    logic [N_CH-1:0]    calc_spk;
    logic [N_CH*CW-1:0] calc_cnt;
    logic [RW-1:0]      calc_refr [N_CH];
    logic [TW-1:0]      calc_total;

    assign step_ready  = (state_q == IDLE) && !img_start;
    assign spike_out   = spike_out_q;
    assign count       = count_q;
    assign spike_total = total_q;
    assign done        = done_q;

    always_comb begin
        calc_spk   = '0;
        calc_cnt   = count_q;
        calc_total = '0;
        for (int i = 0; i < N_CH; i++) begin
            calc_refr[i] = refr_q[i];
        end
        for (int i = 0; i < N_CH; i++) begin
            if (en_hold_q[i]) begin
                if (refr_q[i] != '0) begin
                    calc_refr[i] = refr_q[i] - RW'(1);
                end else begin
                    calc_spk[i] = spk_hold_q[i];
                    if (spk_hold_q[i]) begin
                        calc_refr[i] = REFRAC_V;
                    end
                end
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (en_hold_q[i]) begin
                // Legacy mode clears on the spike stored by the previous
                // step, which lags the input by one step.
                if ((PREV_SPIKE != 0) ? spike_out_q[i] : calc_spk[i]) begin
                    calc_cnt[i*CW +: CW] = '0;
                end else if (count_q[i*CW +: CW] < T_MAX_V) begin
                    calc_cnt[i*CW +: CW] = count_q[i*CW +: CW] + CW'(1);
                end
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            calc_total = calc_total + TW'(calc_spk[i]);
        end
    end

    always_comb begin
        state_d     = state_q;
        spk_hold_d  = spk_hold_q;
        en_hold_d   = en_hold_q;
        spike_out_d = spike_out_q;
        count_d     = count_q;
        total_d     = total_q;
        done_d      = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            refr_d[i] = refr_q[i];
        end
        if (img_start) begin
            // Reinitialise and abort any step in flight without done.
            state_d     = IDLE;
            spike_out_d = '0;
            count_d     = {N_CH{T_MAX_V}};
            total_d     = '0;
            for (int i = 0; i < N_CH; i++) begin
                refr_d[i] = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (step_valid) begin
                        state_d    = CALC;
                        spk_hold_d = spike_in;
                        en_hold_d  = chan_en;
                    end
                end
                CALC: begin
                    state_d     = IDLE;
                    spike_out_d = calc_spk;
                    count_d     = calc_cnt;
                    total_d     = calc_total;
                    done_d      = 1'b1;
                    for (int i = 0; i < N_CH; i++) begin
                        refr_d[i] = calc_refr[i];
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            spk_hold_q  <= '0;
            en_hold_q   <= '0;
            spike_out_q <= '0;
            count_q     <= {N_CH{T_MAX_V}};
            total_q     <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                refr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            spk_hold_q  <= spk_hold_d;
            en_hold_q   <= en_hold_d;
            spike_out_q <= spike_out_d;
            count_q     <= count_d;
            total_q     <= total_d;
            done_q      <= done_d;
            for (int i = 0; i < N_CH; i++) begin
                refr_q[i] <= refr_d[i];
            end
        end
    end

endmodule
